// File: rtl/rx_sext_sequencer_if.sv
// rx_sext_sequencer_if: setting bus, per-channel sample inputs and the tagged
// output stream of rx_sext_sequencer. The master modport is the surrounding
// datapath; the slave modport is the sequencer itself.
// Optional macro RX_SEQ_OVERRUN_CNT_EN adds the overrun_count signal.
interface rx_sext_sequencer_if #(
  parameter int NCHAN = 4
);
  logic [6:0]          serial_addr;
  logic [31:0]         serial_data;
  logic                serial_strobe;
  logic [16*NCHAN-1:0] ch_data;
  logic [NCHAN-1:0]    ch_strobe;
  logic [15:0]         out_data;
  logic [1:0]          out_chan;
  logic                out_strobe;
  logic [NCHAN-1:0]    overrun;
`ifdef RX_SEQ_OVERRUN_CNT_EN
  logic [15:0]         overrun_count;

  modport master (
    output serial_addr, serial_data, serial_strobe, ch_data, ch_strobe,
    input  out_data, out_chan, out_strobe, overrun, overrun_count
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, ch_data, ch_strobe,
    output out_data, out_chan, out_strobe, overrun, overrun_count
  );
`else
  modport master (
    output serial_addr, serial_data, serial_strobe, ch_data, ch_strobe,
    input  out_data, out_chan, out_strobe, overrun
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, ch_data, ch_strobe,
    output out_data, out_chan, out_strobe, overrun
  );
`endif
endinterface

// File: rtl/rx_sext_sequencer.sv
// rx_sext_sequencer: buffers one raw sample per receive channel, round-robin
// schedules pending samples into a single two-stage sign-extension pipeline and
// emits one tagged 16-bit sample stream.
// Optional macro RX_SEQ_OVERRUN_CNT_EN adds a saturating overrun event counter.
module rx_sext_sequencer #(
  parameter int NCHAN     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  rx_sext_sequencer_if.slave bus
);

  localparam logic [6:0] ADDR_WIDTH = 7'(BASE_ADDR);
  localparam logic [6:0] ADDR_CLR   = 7'(BASE_ADDR + 1);

  logic [3:0]       width_q [NCHAN];
  logic [15:0]      hold_q  [NCHAN];
  logic [NCHAN-1:0] pend_q;
  logic [NCHAN-1:0] overrun_q;
  logic [NCHAN-1:0] granted;
  logic [NCHAN-1:0] ovr_event;
  logic [1:0]       ptr_q;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_valid;
  logic             width_wr;
  logic             clr_wr;

  logic             s1_valid_q;
  logic [15:0]      s1_data_q;
  logic [1:0]       s1_chan_q;
  logic [3:0]       s1_field_q;
  logic [15:0]      ext_data;

  logic [15:0]      out_data_q;
  logic [1:0]       out_chan_q;
  logic             out_strobe_q;

  logic             unused_serial;

  assign width_wr      = bus.serial_strobe && (bus.serial_addr == ADDR_WIDTH);
  assign clr_wr        = bus.serial_strobe && (bus.serial_addr == ADDR_CLR);
  assign unused_serial = ^bus.serial_data[31:4*NCHAN];

  // Round-robin search for the first pending channel after the last grant
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      cand = 2'((int'(ptr_q) + k) % NCHAN);
      if (!grant_valid && pend_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-channel grant decode and overrun detection (strobe onto an ungranted pending slot)
  always_comb begin
    granted   = '0;
    ovr_event = '0;
    for (int i = 0; i < NCHAN; i++) begin
      granted[i]   = enable && grant_valid && (grant_idx == 2'(i));
      ovr_event[i] = enable && bus.ch_strobe[i] && pend_q[i] && !granted[i];
    end
  end

  // Sample buffers, pending flags and round-robin pointer; a new strobe always wins the slot
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        hold_q[i] <= '0;
      end
    end else if (!enable) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (bus.ch_strobe[i]) begin
          hold_q[i] <= bus.ch_data[16*i +: 16];
          pend_q[i] <= 1'b1;
        end else if (granted[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        ptr_q <= grant_idx;
      end
    end
  end

  // Per-channel width fields written from the setting bus; kept across enable changes
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++) begin
        width_q[i] <= 4'hF;
      end
    end else if (width_wr) begin
      for (int i = 0; i < NCHAN; i++) begin
        width_q[i] <= bus.serial_data[4*i +: 4];
      end
    end
  end

  // Sticky overrun flags; a new overrun in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (overrun_q & ~(clr_wr ? bus.serial_data[NCHAN-1:0] : {NCHAN{1'b0}}))
                 | ovr_event;
    end
  end

`ifdef RX_SEQ_OVERRUN_CNT_EN
  logic [15:0] ovr_count_q;

  // Saturating count of cycles containing at least one overrun; any clear write zeroes it
  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_count_q <= '0;
    end else if (clr_wr) begin
      ovr_count_q <= '0;
    end else if ((|ovr_event) && (ovr_count_q != 16'hFFFF)) begin
      ovr_count_q <= ovr_count_q + 16'd1;
    end
  end

  assign bus.overrun_count = ovr_count_q;
`endif

  // Stage 1: capture the granted sample together with its width at grant time
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_chan_q  <= '0;
      s1_field_q <= '0;
    end else begin
      s1_valid_q <= enable && grant_valid;
      if (enable && grant_valid) begin
        s1_data_q  <= hold_q[grant_idx];
        s1_chan_q  <= grant_idx;
        s1_field_q <= width_q[grant_idx];
      end
    end
  end

  // Replicate the top valid bit (index = width field) into all higher bits
  always_comb begin
    ext_data = '0;
    for (int j = 0; j < 16; j++) begin
      ext_data[j] = (4'(j) <= s1_field_q) ? s1_data_q[j] : s1_data_q[s1_field_q];
    end
  end

  // Stage 2: register the extended sample and its channel tag
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      out_strobe_q <= enable && s1_valid_q;
      if (enable && s1_valid_q) begin
        out_data_q <= ext_data;
        out_chan_q <= s1_chan_q;
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/rx_sext_sequencer.md
Name: rx_sext_sequencer

Overview:
Time-shares one registered sign-extension stage among NCHAN receive sample channels in the USRP RX datapath. Each channel strobes a raw 16-bit sample whose valid width (1..16 bits) is set per channel over the serial setting bus. The block buffers one sample per channel and round-robin schedules pending samples into the shared extender. It emits a single tagged 16-bit sample stream to the downstream packer/FIFO.

Parameters:
NCHAN, 4, number of requesting channels (1..4)
BASE_ADDR, 0, serial-bus address of the width register; BASE_ADDR+1 is the overrun-clear register

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  block enable; low flushes all state except width settings
serial_addr  in  7  setting bus address
serial_data  in  32  setting bus data
serial_strobe  in  1  setting bus write strobe
ch_data  in  16*NCHAN  raw samples; channel i occupies bits [16i+15:16i], valid bits are LSBs
ch_strobe  in  NCHAN  per-channel sample valid, one-cycle pulse
out_data  out  16  sign-extended sample
out_chan  out  2  channel index of out_data
out_strobe  out  1  out_data/out_chan valid, one-cycle pulse
overrun  out  NCHAN  sticky per-channel overrun flags

Behaviour:
- Reset: out_data=0, out_chan=0, out_strobe=0, overrun=0, pend=0, RR pointer=0, all width fields=15 (16-bit pass-through).
- Width register: write at BASE_ADDR loads field i = serial_data[4i+3:4i]; bits_in(i) = field+1. Write at BASE_ADDR+1 with serial_data[i]=1 clears overrun[i]. Other addresses are ignored.
- Capture (enable=1): ch_strobe[i] latches ch_data slice into hold[i] and sets pend[i] on the next edge.
- Overrun: ch_strobe[i] while pend[i]=1 and channel i not granted this cycle -> overrun[i]<=1, hold[i] overwritten (newest sample wins), pend stays 1.
- Simultaneous strobe and grant on the same channel: the granted sample is the old hold[i], the new sample is latched, pend[i] stays 1, no overrun.
- Arbiter: each cycle with any pend set, grant exactly one channel, searching round-robin from ptr+1 (mod NCHAN). On grant: pend[g] cleared (unless re-strobed), ptr<=g. Maximum throughput is one sample per clock.
- Stage 1 (grant edge): register hold[g], g, and bits_in(g). Width is sampled here, so a width change affects only samples not yet granted.
- Stage 2: out_data <= sample[bits_in-1:0] with bit bits_in-1 replicated into bits 15:bits_in. out_chan <= g; out_strobe <= 1.
- Latency, uncontended: ch_strobe in cycle t -> out_strobe high in cycle t+3. With K channels pending, worst-case wait is NCHAN-1 extra cycles.
- enable=0: ch_strobe ignored, pend cleared, pipeline valid bits cleared (out_strobe=0 next cycle), ptr held, widths and overrun held.
- Reset mid-operation: all in-flight samples are dropped and no out_strobe follows.

Optional Feature:
RX_SEQ_OVERRUN_CNT_EN: when defined, adds output overrun_count[15:0]. It increments once per cycle in which any overrun event occurs and saturates at 0xFFFF. It is cleared by reset or by any write to BASE_ADDR+1. When not defined, the port and counter are absent; overrun flags are unchanged.

Test Plan:
- Reset defaults: strobe ch0 with 0x8001 -> 3 cycles later out_data=0x8001, out_chan=0, single out_strobe.
- Width 12 on ch1 (write BASE_ADDR, data 0x00B0), ch1 sample 0x0800 -> out_data=0xF800. Sample 0x07FF -> 0x07FF. Sample 0xF7FF (upper junk) -> 0x07FF.
- All 4 channels strobe in the same cycle (ptr=0) -> outputs on 4 consecutive cycles, order ch1,ch2,ch3,ch0.
- ch2 strobed twice (0x0001 then 0x0002) while starved by saturated ch0/ch1/ch3 traffic -> overrun[2]=1, ch2 emits 0x0002 only. Write BASE_ADDR+1 data 0x4 -> overrun[2]=0.
- Strobe ch3, deassert enable the next cycle -> no out_strobe, pend cleared. Re-enable with a width write pending -> widths retained.
- With RX_SEQ_OVERRUN_CNT_EN: 3 overrun events -> overrun_count=3. Clear write -> 0. Force 0xFFFF -> stays 0xFFFF on further overruns.
